// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the shared memory arbiter.
// The arbiter takes the slave view; whoever drives requests and models mem_system takes the master view.
interface mem_arbiter_if;
    logic        i_rd;
    logic [15:0] i_addr;
    logic        i_flush;
    logic [15:0] i_dout;
    logic        i_done;
    logic        i_stall;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic [15:0] d_dout;
    logic        d_done;
    logic        d_stall;
    logic        err;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_done;
    logic        mem_stall;
    logic        mem_err;

    modport slave (
        input  i_rd, i_addr, i_flush, d_rd, d_wr, d_addr, d_din,
               mem_dout, mem_done, mem_stall, mem_err,
        output i_dout, i_done, i_stall, d_dout, d_done, d_stall, err,
               mem_rd, mem_wr, mem_addr, mem_din
    );

    modport master (
        output i_rd, i_addr, i_flush, d_rd, d_wr, d_addr, d_din,
               mem_dout, mem_done, mem_stall, mem_err,
        input  i_dout, i_done, i_stall, d_dout, d_done, d_stall, err,
               mem_rd, mem_wr, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch and data stages, one transaction at a time,
// with data priority and internal draining of flushed fetches.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_D  = 2'd1;
    localparam logic [1:0] BUSY_I  = 2'd2;
    localparam logic [1:0] DRAIN_I = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] drain_addr;
    logic        err_q;
    logic        d_req;
    logic        i_issue;
    logic        own_d;
    logic        own_i;
    logic        owned;
    logic        draining;
    logic        err_set;
    logic        unused_mem_stall;

    // mem_stall is informational only; mem_done alone ends a transaction.
    assign unused_mem_stall = bus.mem_stall;

    assign d_req    = bus.d_rd | bus.d_wr;
    assign i_issue  = bus.i_rd & ~bus.i_flush;
    assign draining = (state == DRAIN_I);

    // Owner this cycle: the transaction in flight, or the one IDLE issues right now.
    always_comb begin
        own_d = 1'b0;
        own_i = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    own_d = d_req;
                    own_i = ~d_req & i_issue;
                end
                BUSY_D:  own_d = 1'b1;
                default: own_i = 1'b1;
            endcase
        end
    end
    assign owned = own_d | own_i;

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = 16'h0000;
        bus.mem_din  = 16'h0000;
        if (own_d) begin
            bus.mem_rd   = bus.d_rd;
            bus.mem_wr   = bus.d_wr;
            bus.mem_addr = bus.d_addr;
            bus.mem_din  = bus.d_din;
        end else if (own_i) begin
            // Once flushed, the requester may move on; keep the issued address on the port.
            bus.mem_rd   = 1'b1;
            bus.mem_addr = (draining || (state == BUSY_I && bus.i_flush)) ? drain_addr : bus.i_addr;
        end
    end

    assign bus.d_done  = own_d & bus.mem_done;
    assign bus.i_done  = own_i & bus.mem_done & ~draining & ~bus.i_flush;
    assign bus.d_dout  = bus.mem_dout;
    assign bus.i_dout  = bus.mem_dout;
    assign bus.d_stall = d_req & ~bus.d_done;
    assign bus.i_stall = bus.i_rd & ~bus.i_done;
    assign bus.err     = err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!bus.mem_done) begin
                    if (d_req)        state_nxt = BUSY_D;
                    else if (i_issue) state_nxt = BUSY_I;
                end
            end
            BUSY_D: if (bus.mem_done) state_nxt = IDLE;
            BUSY_I: begin
                if (bus.mem_done)     state_nxt = IDLE;
                else if (bus.i_flush) state_nxt = DRAIN_I;
            end
            default: if (bus.mem_done) state_nxt = IDLE;
        endcase
    end

    assign err_set = (bus.d_rd & bus.d_wr)
                   | (owned & bus.mem_err)
                   | ((state == BUSY_D) & ~d_req)
                   | ((state == BUSY_I) & ~bus.i_rd & ~bus.i_flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_q | err_set;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && own_i) drain_addr <= bus.i_addr;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized requesters against a memory model,
// with a transaction-level reference checked every cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed pattern overlaid by writes; the memory side and the reference keep separate copies.
    logic [15:0] mem_w [logic [15:0]];
    logic [15:0] ref_w [logic [15:0]];

    function automatic logic [15:0] seed_val(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return mem_w.exists(a) ? mem_w[a] : seed_val(a);
    endfunction
    function automatic logic [15:0] ref_val(input logic [15:0] a);
        return ref_w.exists(a) ? ref_w[a] : seed_val(a);
    endfunction
    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        mem_w[a] = v;
        ref_w[a] = v;
    endtask

    // Memory responder state
    bit          mb_busy = 1'b0;
    int          mb_left = 0;
    int          force_lat = -1;
    logic        err_inject = 1'b0;
    logic        c_rst, c_done, c_wr;
    logic [15:0] c_addr, c_din;
    logic        d_done_s = 1'b0;
    logic        i_done_s = 1'b0;

    task automatic drive_mem();
        #1;
        bus.mem_done  = 1'b0;
        bus.mem_stall = 1'b0;
        bus.mem_err   = err_inject;
        bus.mem_dout  = 16'($urandom);
        if (!rst && (bus.mem_rd || bus.mem_wr)) begin
            if (!mb_busy) begin
                mb_busy = 1'b1;
                mb_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (mb_left == 0) begin
                bus.mem_done = 1'b1;
                if (bus.mem_rd) bus.mem_dout = mem_val(bus.mem_addr);
            end else begin
                bus.mem_stall = 1'b1;
            end
        end
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        c_rst    = rst;
        c_done   = bus.mem_done;
        c_wr     = bus.mem_wr;
        c_addr   = bus.mem_addr;
        c_din    = bus.mem_din;
        d_done_s = bus.d_done;
        i_done_s = bus.i_done;
        @(posedge clk);
        if (c_rst) mb_busy = 1'b0;
        else if (c_done) begin
            if (c_wr) mem_w[c_addr] = c_din;
            mb_busy = 1'b0;
        end else if (mb_busy) mb_left--;
        #1;
    endtask

    task automatic cycle();
        drive_mem();
        tick();
    endtask

    // Reference: who is being served (0 none, 1 data, 2 fetch), whether that fetch is dead, its address, sticky error.
    int          m_cur = 0;
    logic        m_dead = 1'b0;
    logic [15:0] m_fa = 16'h0000;
    logic        m_err = 1'b0;

    always @(negedge clk) begin : compare
        int          own;
        logic        dead_now, e_rd, e_wr, e_ddone, e_idone, e_dstall, e_istall;
        logic [15:0] e_addr, e_din;
        if (rst)                            own = 0;
        else if (m_cur != 0)                own = m_cur;
        else if (bus.d_rd || bus.d_wr)      own = 1;
        else if (bus.i_rd && !bus.i_flush)  own = 2;
        else                                own = 0;
        e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_din = 16'h0000;
        if (own == 1) begin
            e_rd = bus.d_rd; e_wr = bus.d_wr; e_addr = bus.d_addr; e_din = bus.d_din;
        end else if (own == 2) begin
            e_rd = 1'b1;
            e_addr = (m_cur == 2) ? m_fa : bus.i_addr;
        end
        dead_now = m_dead || (m_cur == 2 && bus.i_flush);
        e_ddone  = bus.mem_done && own == 1;
        e_idone  = bus.mem_done && own == 2 && !dead_now;
        e_dstall = (bus.d_rd || bus.d_wr) && !e_ddone;
        e_istall = bus.i_rd && !e_idone;

        chk("mem_rd", bus.mem_rd, e_rd);
        chk("mem_wr", bus.mem_wr, e_wr);
        chk("mem_addr", bus.mem_addr, e_addr);
        if (e_wr || rst) chk("mem_din", bus.mem_din, e_din);
        chk("d_done", bus.d_done, e_ddone);
        chk("i_done", bus.i_done, e_idone);
        chk("d_stall", bus.d_stall, e_dstall);
        chk("i_stall", bus.i_stall, e_istall);
        chk("err", bus.err, m_err);
        if (e_ddone && bus.d_rd) chk("d_dout", bus.d_dout, ref_val(bus.d_addr));
        if (e_idone) chk("i_dout", bus.i_dout, ref_val(e_addr));

        if (rst) begin
            m_cur = 0; m_dead = 1'b0; m_err = 1'b0;
        end else begin
            m_err = m_err | (bus.d_rd & bus.d_wr) | ((own != 0) & bus.mem_err)
                  | ((m_cur == 1) & ~(bus.d_rd | bus.d_wr))
                  | ((m_cur == 2) & ~m_dead & ~bus.i_rd & ~bus.i_flush);
            if (e_ddone && bus.d_wr) ref_w[bus.d_addr] = bus.d_din;
            if (own == 2 && m_cur == 0) m_fa = bus.i_addr;
            if (bus.mem_done && own != 0) begin
                m_cur = 0; m_dead = 1'b0;
            end else begin
                m_cur = own; m_dead = dead_now;
            end
        end
    end

    initial begin : stim
        bit d_act, i_act, hung;
        int d_wait, i_wait;
        rst = 1'b1;
        bus.i_rd = 1'b0; bus.i_addr = 16'h0; bus.i_flush = 1'b0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_din = 16'h0;
        bus.mem_dout = 16'h0; bus.mem_done = 1'b0; bus.mem_stall = 1'b0; bus.mem_err = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        drive_mem();
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mem_wr", bus.mem_wr, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_din", bus.mem_din, 16'h0000);
        chk("rst_i_done", bus.i_done, 1'b0);
        chk("rst_d_done", bus.d_done, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_i_stall", bus.i_stall, 1'b0);
        chk("rst_d_stall", bus.d_stall, 1'b0);
        tick();

        // Single-cycle fetch hit
        preload(16'h0010, 16'h1234);
        force_lat = 0;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0010;
        drive_mem();
        chk("hit_mem_rd", bus.mem_rd, 1'b1);
        chk("hit_mem_addr", bus.mem_addr, 16'h0010);
        chk("hit_i_done", bus.i_done, 1'b1);
        chk("hit_i_dout", bus.i_dout, 16'h1234);
        chk("hit_i_stall", bus.i_stall, 1'b0);
        tick();
        bus.i_rd = 1'b0;
        drive_mem();
        chk("hit_idle_mem_rd", bus.mem_rd, 1'b0);
        tick();

        // Data store wins over a simultaneous fetch; fetch follows on the next cycle
        force_lat = 3;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0100;
        bus.d_wr = 1'b1; bus.d_addr = 16'h0200; bus.d_din = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            drive_mem();
            chk("cf_mem_wr", bus.mem_wr, 1'b1);
            chk("cf_mem_addr", bus.mem_addr, 16'h0200);
            chk("cf_mem_din", bus.mem_din, 16'hBEEF);
            chk("cf_i_stall", bus.i_stall, 1'b1);
            chk("cf_d_done", bus.d_done, (k == 3) ? 1'b1 : 1'b0);
            tick();
        end
        bus.d_wr = 1'b0;
        force_lat = 0;
        drive_mem();
        chk("cf_fetch_rd", bus.mem_rd, 1'b1);
        chk("cf_fetch_addr", bus.mem_addr, 16'h0100);
        chk("cf_fetch_done", bus.i_done, 1'b1);
        tick();
        bus.i_rd = 1'b0;

        // Flush during a fetch miss
        force_lat = 5;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0040;
        drive_mem();
        chk("fl_mem_addr0", bus.mem_addr, 16'h0040);
        tick();
        bus.i_rd = 1'b0; bus.i_flush = 1'b1; bus.i_addr = 16'h0999;
        drive_mem();
        chk("fl_mem_addr1", bus.mem_addr, 16'h0040);
        chk("fl_i_done1", bus.i_done, 1'b0);
        tick();
        bus.i_flush = 1'b0;
        for (int k = 2; k < 6; k++) begin
            drive_mem();
            chk("fl_mem_rd", bus.mem_rd, 1'b1);
            chk("fl_mem_addr", bus.mem_addr, 16'h0040);
            chk("fl_i_done", bus.i_done, 1'b0);
            tick();
        end
        force_lat = 0;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0080;
        drive_mem();
        chk("fl_new_addr", bus.mem_addr, 16'h0080);
        chk("fl_new_done", bus.i_done, 1'b1);
        tick();
        bus.i_rd = 1'b0;

        // Load miss
        preload(16'h0300, 16'h00FF);
        force_lat = 3;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0300;
        for (int k = 0; k < 4; k++) begin
            drive_mem();
            chk("ld_d_stall", bus.d_stall, (k < 3) ? 1'b1 : 1'b0);
            chk("ld_d_done", bus.d_done, (k == 3) ? 1'b1 : 1'b0);
            if (k == 3) chk("ld_d_dout", bus.d_dout, 16'h00FF);
            tick();
        end
        bus.d_rd = 1'b0;

        // Read and write together is an error, sticky until reset
        force_lat = 0;
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0500; bus.d_din = 16'h7777;
        cycle();
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        drive_mem();
        chk("e1_err", bus.err, 1'b1);
        tick();
        drive_mem();
        chk("e1_err_sticky", bus.err, 1'b1);
        tick();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_mem();
        chk("e1_err_cleared", bus.err, 1'b0);
        tick();

        // Memory error while a fetch is outstanding
        force_lat = 2;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0020;
        cycle();
        err_inject = 1'b1;
        cycle();
        err_inject = 1'b0;
        drive_mem();
        chk("e2_err", bus.err, 1'b1);
        tick();
        bus.i_rd = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive_mem();
        chk("e2_err_cleared", bus.err, 1'b0);
        tick();

        // Reset in the middle of a data store
        force_lat = 6;
        bus.d_wr = 1'b1; bus.d_addr = 16'h0600; bus.d_din = 16'h1111;
        cycle();
        cycle();
        rst = 1'b1; bus.d_wr = 1'b0;
        drive_mem();
        chk("rb_rst_mem_wr", bus.mem_wr, 1'b0);
        tick();
        rst = 1'b0;
        drive_mem();
        chk("rb_mem_rd", bus.mem_rd, 1'b0);
        chk("rb_mem_wr", bus.mem_wr, 1'b0);
        chk("rb_mem_addr", bus.mem_addr, 16'h0000);
        chk("rb_mem_din", bus.mem_din, 16'h0000);
        tick();
        force_lat = 0;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0600;
        drive_mem();
        chk("rb_next_rd", bus.mem_rd, 1'b1);
        chk("rb_next_addr", bus.mem_addr, 16'h0600);
        chk("rb_next_done", bus.d_done, 1'b1);
        tick();
        bus.d_rd = 1'b0;

        // Randomized traffic from both requesters
        force_lat = -1;
        d_act = 1'b0; i_act = 1'b0; hung = 1'b0; d_wait = 0; i_wait = 0;
        d_done_s = 1'b0; i_done_s = 1'b0;
        for (int n = 0; n < 3000 && !hung; n++) begin
            if (d_act && d_done_s) begin
                d_act = 1'b0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
            end
            if (!d_act && $urandom_range(0, 3) == 0) begin
                d_act = 1'b1; d_wait = 0;
                if ($urandom_range(0, 1) == 1) begin bus.d_wr = 1'b1; bus.d_rd = 1'b0; end
                else begin bus.d_rd = 1'b1; bus.d_wr = 1'b0; end
                bus.d_addr = 16'($urandom_range(0, 31));
                bus.d_din  = 16'($urandom);
            end
            bus.i_flush = 1'b0;
            if (i_act && i_done_s) begin
                i_act = 1'b0; bus.i_rd = 1'b0;
            end
            if (i_act && $urandom_range(0, 9) == 0) begin
                i_act = 1'b0; bus.i_rd = 1'b0; bus.i_flush = 1'b1;
            end else if (!i_act && $urandom_range(0, 1) == 1) begin
                i_act = 1'b1; i_wait = 0;
                bus.i_rd = 1'b1;
                bus.i_addr = 16'($urandom_range(0, 31));
            end
            cycle();
            if (d_act) d_wait++;
            if (i_act) i_wait++;
            if (d_wait > 60 || i_wait > 200) begin
                checks++;
                errors++;
                $display("FAIL watchdog: request pending d=%0d i=%0d cycles, limit 60/200", d_wait, i_wait);
                hung = 1'b1;
            end
        end
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.i_rd = 1'b0; bus.i_flush = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
